// File: rtl/axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_cmd_master
// Brief    : Converts a command stream into single-beat AXI4 transactions and
//            returns one response per command, in command order.
//            Optional error counter: define AXI_CMD_MASTER_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================

package axi_cmd_master_pkg;
    localparam int unsigned AXI_ADDR_WIDTH = 64;
    localparam int unsigned AXI_DATA_WIDTH = 64;
    localparam int unsigned AXI_ID_WIDTH   = 4;
    localparam int unsigned AXI_USER_WIDTH = 1;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]   data;
        logic [AXI_DATA_WIDTH/8-1:0] strb;
        logic                        last;
        logic [AXI_USER_WIDTH-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;
endpackage

module axi_cmd_master #(
    parameter type         req_t           = axi_cmd_master_pkg::axi_req_t,
    parameter type         resp_t          = axi_cmd_master_pkg::axi_resp_t,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CMD_FIFO_DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_write_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [1:0]              rsp_resp_o,
    output req_t                    req_o,
    input  resp_t                   resp_i,
    output logic                    busy_o,
    output logic [15:0]             err_cnt_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CMD_PTR_W  = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int unsigned CMD_CNT_W  = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int unsigned RSP_PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned RSP_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } cmd_entry_t;

    typedef struct packed {
        logic                  write;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
    } rsp_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t                 state;
    logic                   ready_en;
    logic                   aw_valid, w_valid, ar_valid;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [STRB_WIDTH-1:0]  strb_q;
    logic                   last_write;
    logic [RSP_CNT_W-1:0]   credits;

    cmd_entry_t             cmd_mem [CMD_FIFO_DEPTH];
    cmd_entry_t             cmd_in, cmd_head;
    logic [CMD_PTR_W-1:0]   cmd_wr_ptr, cmd_rd_ptr;
    logic [CMD_CNT_W-1:0]   cmd_count;
    logic                   cmd_full, cmd_empty, cmd_push, cmd_pop, issue_gate;

    rsp_entry_t             rsp_mem [MAX_OUTSTANDING];
    rsp_entry_t             rsp_in, rsp_head;
    logic [RSP_PTR_W-1:0]   rsp_wr_ptr, rsp_rd_ptr;
    logic [RSP_CNT_W-1:0]   rsp_count;
    logic                   rsp_push, rsp_pop, b_hs, r_hs;
    logic                   unused_resp;

    assign cmd_in    = {cmd_write_i, cmd_addr_i, cmd_data_i, cmd_strb_i};
    assign cmd_head  = cmd_mem[cmd_rd_ptr];
    assign cmd_full  = (cmd_count == CMD_CNT_W'(CMD_FIFO_DEPTH));
    assign cmd_empty = (cmd_count == '0);

    // A type switch only issues once every earlier response has been consumed.
    assign issue_gate = (credits < RSP_CNT_W'(MAX_OUTSTANDING)) &&
                        ((credits == '0) || (cmd_head.write == last_write));
    assign cmd_pop     = (state == IDLE) && issue_gate && !cmd_empty;
    assign cmd_ready_o = ready_en && (!cmd_full || cmd_pop);
    assign cmd_push    = cmd_valid_i && cmd_ready_o;

    assign b_hs     = resp_i.b_valid && ready_en;
    assign r_hs     = resp_i.r_valid && ready_en;
    assign rsp_push = b_hs || r_hs;
    assign rsp_in   = b_hs ? {1'b1, {DATA_WIDTH{1'b0}}, resp_i.b.resp}
                           : {1'b0, resp_i.r.data, resp_i.r.resp};
    assign rsp_head    = rsp_mem[rsp_rd_ptr];
    assign rsp_valid_o = (rsp_count != '0);
    assign rsp_write_o = rsp_head.write;
    assign rsp_data_o  = rsp_head.data;
    assign rsp_resp_o  = rsp_head.resp;
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    assign busy_o      = !cmd_empty || (credits != '0);
    assign unused_resp = ^resp_i;

    always_comb begin
        req_o          = '0;
        req_o.aw.addr  = addr_q;
        req_o.aw.size  = AXI_SIZE;
        req_o.aw.burst = 2'b01;
        req_o.aw_valid = aw_valid;
        req_o.w.data   = data_q;
        req_o.w.strb   = strb_q;
        req_o.w.last   = 1'b1;
        req_o.w_valid  = w_valid;
        req_o.ar.addr  = addr_q;
        req_o.ar.size  = AXI_SIZE;
        req_o.ar.burst = 2'b01;
        req_o.ar_valid = ar_valid;
        req_o.b_ready  = ready_en;
        req_o.r_ready  = ready_en;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push)
                cmd_wr_ptr <= (cmd_wr_ptr == CMD_PTR_W'(CMD_FIFO_DEPTH - 1)) ? '0 : cmd_wr_ptr + 1'b1;
            if (cmd_pop)
                cmd_rd_ptr <= (cmd_rd_ptr == CMD_PTR_W'(CMD_FIFO_DEPTH - 1)) ? '0 : cmd_rd_ptr + 1'b1;
            if (cmd_push && !cmd_pop)      cmd_count <= cmd_count + 1'b1;
            else if (!cmd_push && cmd_pop) cmd_count <= cmd_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)                 credits <= '0;
        else if (cmd_pop && !rsp_pop) credits <= credits + 1'b1;
        else if (!cmd_pop && rsp_pop) credits <= credits - 1'b1;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state      <= IDLE;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            ar_valid   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            last_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        addr_q     <= cmd_head.addr & ADDR_MASK;
                        data_q     <= cmd_head.data;
                        strb_q     <= cmd_head.strb;
                        last_write <= cmd_head.write;
                        if (cmd_head.write) begin
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            state    <= WR;
                        end else begin
                            ar_valid <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently, in any order.
                    if (aw_valid && resp_i.aw_ready) aw_valid <= 1'b0;
                    if (w_valid && resp_i.w_ready)   w_valid  <= 1'b0;
                    if ((!aw_valid || resp_i.aw_ready) && (!w_valid || resp_i.w_ready))
                        state <= IDLE;
                end
                RD: begin
                    if (resp_i.ar_ready) begin
                        ar_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_in;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push)
                rsp_wr_ptr <= (rsp_wr_ptr == RSP_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rsp_wr_ptr + 1'b1;
            if (rsp_pop)
                rsp_rd_ptr <= (rsp_rd_ptr == RSP_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rsp_rd_ptr + 1'b1;
            if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + 1'b1;
            else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - 1'b1;
        end
    end

`ifdef AXI_CMD_MASTER_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic        err_event;

    assign err_event = (b_hs && (resp_i.b.resp != 2'b00)) || (r_hs && (resp_i.r.resp != 2'b00));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)                             err_cnt <= '0;
        else if (err_event && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_cmd_master
// Brief    : Self-checking bench for axi_cmd_master with a memory slave and a
//            command-order response model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_master;
    import axi_cmd_master_pkg::*;

    typedef struct {
        logic        write;
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rbeat_t;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [63:0] cmd_addr, cmd_data;
    logic [7:0]  cmd_strb;
    logic        rsp_valid, rsp_write;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_resp;
    axi_req_t    req;
    axi_resp_t   resp = '0;
    logic        busy;
    logic [15:0] err_cnt;

    int compared = 0;
    int mismatched = 0;

    exp_t        exp_q[$];
    logic [63:0] exp_addr_q[$];
    logic [63:0] mmem [logic [63:0]];
    logic [63:0] smem [logic [63:0]];
    int          exp_err = 0;

    bit          rsp_rand = 0;
    bit          rsp_hold_ready = 1;
    bit          slv_rand = 0;
    int          aw_hold = 0;
    int          ar_hs_cnt = 0, b_hs_cnt = 0, rsp_cnt = 0, violations = 0;
    bit          w_first = 0;
    logic        last_write;
    logic [63:0] last_data;
    logic [1:0]  last_resp;

    always #5 clk = ~clk;

    axi_cmd_master #(
        .req_t          (axi_req_t),
        .resp_t         (axi_resp_t),
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .MAX_OUTSTANDING(4),
        .CMD_FIFO_DEPTH (4)
    ) dut (
        .clk_i      (clk),
        .arst_ni    (arst_ni),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_data_i (cmd_data),
        .cmd_strb_i (cmd_strb),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_write_o(rsp_write),
        .rsp_data_o (rsp_data),
        .rsp_resp_o (rsp_resp),
        .req_o      (req),
        .resp_i     (resp),
        .busy_o     (busy),
        .err_cnt_o  (err_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Reference: each accepted command predicts its response from plain memory semantics.
    task automatic push_cmd(input logic wr, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s);
        logic [63:0] al;
        exp_t        e;
        int          n;
        al        = a & ~64'h7;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        e.write = wr;
        e.data  = '0;
        if (al < 64'h8000_0000) begin
            e.resp = 2'b00;
            if (wr) mmem[al] = merge(mmem.exists(al) ? mmem[al] : 64'h0, d, s);
            else    e.data = mmem.exists(al) ? mmem[al] : 64'h0;
        end else begin
            e.resp = 2'b11;
        end
        if (e.resp != 2'b00) exp_err++;
        exp_q.push_back(e);
        exp_addr_q.push_back(al);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", {exp_q.size() != 0, busy}, 2'b00);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold_ready;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp", {rsp_write, rsp_data, rsp_resp}, {e.write, e.data, e.resp});
                last_write = rsp_write;
                last_data  = rsp_data;
                last_resp  = rsp_resp;
                rsp_cnt++;
            end
        end
    end

    always @(negedge clk) begin : slave
        axi_req_t    req_s;
        axi_resp_t   resp_s;
        rbeat_t      rq[$];
        rbeat_t      rb;
        logic [1:0]  bq[$];
        logic        aw_pend, w_pend;
        logic [63:0] aw_a, w_d, ea;
        logic [7:0]  w_s;
        if (!arst_ni) begin
            rq.delete();
            bq.delete();
            aw_pend = 0;
            w_pend  = 0;
            resp    = '0;
            req_s   = '0;
            resp_s  = '0;
        end else begin
            // Valids held and payload stable until handshake.
            if (req_s.aw_valid && !resp_s.aw_ready && (!req.aw_valid || req.aw != req_s.aw)) violations++;
            if (req_s.w_valid  && !resp_s.w_ready  && (!req.w_valid  || req.w  != req_s.w))  violations++;
            if (req_s.ar_valid && !resp_s.ar_ready && (!req.ar_valid || req.ar != req_s.ar)) violations++;
            if (req_s.w_valid && resp_s.w_ready) begin
                if (!aw_pend && !(req_s.aw_valid && resp_s.aw_ready)) w_first = 1;
                w_pend = 1;
                w_d    = req_s.w.data;
                w_s    = req_s.w.strb;
                check("w_last", req_s.w.last, 1'b1);
            end
            if (req_s.aw_valid && resp_s.aw_ready) begin
                aw_pend = 1;
                aw_a    = req_s.aw.addr;
                ea      = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 64'hX;
                check("aw_fields", {req_s.aw.id, req_s.aw.addr, req_s.aw.len, req_s.aw.size, req_s.aw.burst},
                      {4'd0, ea, 8'd0, 3'd3, 2'd1});
            end
            if (req_s.ar_valid && resp_s.ar_ready) begin
                ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 64'hX;
                check("ar_fields", {req_s.ar.id, req_s.ar.addr, req_s.ar.len, req_s.ar.size, req_s.ar.burst},
                      {4'd0, ea, 8'd0, 3'd3, 2'd1});
                if (req_s.ar.addr < 64'h8000_0000) begin
                    rb.d = smem.exists(req_s.ar.addr) ? smem[req_s.ar.addr] : 64'h0;
                    rb.r = 2'b00;
                end else begin
                    rb.d = 64'h0;
                    rb.r = 2'b11;
                end
                rq.push_back(rb);
                ar_hs_cnt++;
            end
            if (resp_s.b_valid && req_s.b_ready) begin
                void'(bq.pop_front());
                b_hs_cnt++;
            end
            if (resp_s.r_valid && req_s.r_ready) void'(rq.pop_front());
            if (aw_pend && w_pend) begin
                if (aw_a < 64'h8000_0000) begin
                    smem[aw_a] = merge(smem.exists(aw_a) ? smem[aw_a] : 64'h0, w_d, w_s);
                    bq.push_back(2'b00);
                end else begin
                    bq.push_back(2'b11);
                end
                aw_pend = 0;
                w_pend  = 0;
            end
            resp = '0;
            if (bq.size() != 0) begin
                resp.b_valid = 1'b1;
                resp.b.resp  = bq[0];
            end
            if (rq.size() != 0) begin
                resp.r_valid = 1'b1;
                resp.r.data  = rq[0].d;
                resp.r.resp  = rq[0].r;
                resp.r.last  = 1'b1;
            end
            if (aw_hold > 0) begin
                resp.aw_ready = 1'b0;
                if (req.aw_valid) aw_hold--;
            end else begin
                resp.aw_ready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            resp.w_ready  = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            resp.ar_ready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            req_s  = req;
            resp_s = resp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, a0, r0, n;
        arst_ni   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_strb  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, rsp_valid, cmd_ready, busy, err_cnt},
              '0);
        arst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", cmd_ready, 1'b1);
        @(negedge clk);

        // Write then read back, with issue latency checks on the first write.
        push_cmd(1'b1, 64'h4000_0000, 64'hFEDC_BA98_7654_3210, 8'hFF);
        check("lat_edge_n", {req.aw_valid, req.w_valid}, 2'b00);
        @(negedge clk);
        check("lat_edge_n1", {req.aw_valid, req.w_valid}, 2'b11);
        push_cmd(1'b0, 64'h4000_0000, 64'h0, 8'h00);
        wait_drain();
        check("t1_read", {last_write, last_data, last_resp}, {1'b0, 64'hFEDC_BA98_7654_3210, 2'b00});

        // Three byte-strobed writes, then a read.
        push_cmd(1'b1, 64'h4000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA3);
        push_cmd(1'b1, 64'h4000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5C);
        push_cmd(1'b1, 64'h4000_0000, 64'h0, 8'h55);
        push_cmd(1'b0, 64'h4000_0000, 64'h0, 8'h00);
        wait_drain();
        check("t2_read", {last_write, last_data}, {1'b0, 64'hFF00_FF00_FF00_FF00});

        // AW held off for 5 cycles while W is accepted.
        aw_hold = 5;
        w_first = 0;
        b0 = b_hs_cnt;
        push_cmd(1'b1, 64'h4000_0008, {$urandom, $urandom}, 8'hFF);
        wait_drain();
        check("t3_w_first", w_first, 1'b1);
        check("t3_single_b", b_hs_cnt - b0, 1);
        check("t3_protocol", violations, 0);

        // Credit limit with response path stalled.
        rsp_hold_ready = 0;
        a0 = ar_hs_cnt;
        r0 = rsp_cnt;
        for (int i = 0; i < 8; i++) push_cmd(1'b0, 64'h4000_0000 + 64'(i % 3) * 8, 64'h0, 8'h00);
        repeat (20) @(negedge clk);
        check("t4_ar_count", ar_hs_cnt - a0, 4);
        check("t4_cmd_full", cmd_ready, 1'b0);
        check("t4_rsp_waiting", rsp_valid, 1'b1);
        rsp_hold_ready = 1;
        wait_drain();
        check("t4_rsp_count", rsp_cnt - r0, 8);

        // Unmapped address returns DECERR.
        push_cmd(1'b1, 64'h9000_0000, {$urandom, $urandom}, 8'hFF);
        wait_drain();
        check("t5_resp", {last_write, last_resp}, {1'b1, 2'b11});
`ifdef AXI_CMD_MASTER_ERR_CNT_EN
        check("t5_err_cnt", err_cnt, exp_err[15:0]);
`else
        check("t5_err_cnt", err_cnt, 16'h0);
`endif

        // Randomized traffic with random back-pressure on every channel.
        slv_rand = 1;
        rsp_rand = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0)
                push_cmd(1'($urandom_range(0, 1)), 64'h9000_0000 + 64'($urandom_range(0, 255)),
                         {$urandom, $urandom}, 8'($urandom));
            else
                push_cmd(1'($urandom_range(0, 1)), 64'h4000_0000 + 64'($urandom_range(0, 3)) * 8 + 64'($urandom_range(0, 7)),
                         {$urandom, $urandom}, 8'($urandom));
        end
        wait_drain();
        check("rand_protocol", violations, 0);
`ifdef AXI_CMD_MASTER_ERR_CNT_EN
        check("rand_err_cnt", err_cnt, exp_err[15:0]);
`else
        check("rand_err_cnt", err_cnt, 16'h0);
`endif

        // Asynchronous reset with a write stalled on AW and two credits held.
        slv_rand       = 0;
        rsp_rand       = 0;
        rsp_hold_ready = 0;
        push_cmd(1'b1, 64'h4000_0000, {$urandom, $urandom}, 8'hFF);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_rsp", rsp_valid, 1'b1);
        aw_hold = 30;
        push_cmd(1'b1, 64'h4000_0100, {$urandom, $urandom}, 8'hFF);
        n = 0;
        while (!req.aw_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_aw_pending", req.aw_valid, 1'b1);
        #1;
        arst_ni = 1'b0;
        #1;
        check("t6_async_reset",
              {req.aw_valid, req.w_valid, req.ar_valid, rsp_valid, cmd_ready, busy, err_cnt}, '0);
        exp_q.delete();
        exp_addr_q.delete();
        exp_err = 0;
        aw_hold = 0;
        rsp_hold_ready = 1;
        @(negedge clk);
        @(negedge clk);
        arst_ni = 1'b1;
        @(negedge clk);
        r0 = rsp_cnt;
        push_cmd(1'b0, 64'h4000_0000, 64'h0, 8'h00);
        wait_drain();
        check("t6_read_after_reset", {rsp_cnt - r0, last_write, last_resp}, {32'd1, 1'b0, 2'b00});
        check("t6_err_cnt", err_cnt, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_cmd_master.md
Name: axi_cmd_master

Overview:
- Synthesizable AXI4 master engine that turns a simple command stream (read/write, address, data, strobe) into single-beat AXI transactions on a `req_t`/`resp_t` port pair.
- Returns one response record per command, in command order.
- Successor to the behavioural per-channel master tasks: data width and outstanding depth are parametrised, and AW/W issue concurrently under credit-based flow control.
- Used as an on-chip traffic source and as an external-master stand-in on the SoC master port.

Parameters:
- req_t, logic, AXI request struct type (aw/w/ar/b_ready/r_ready fields).
- resp_t, logic, AXI response struct type.
- ADDR_WIDTH, 64, command/AXI address width.
- DATA_WIDTH, 64, data width; power of two, 8..1024.
- MAX_OUTSTANDING, 4, max commands issued but response not yet consumed; power of two, >=1.
- CMD_FIFO_DEPTH, 4, command FIFO depth; power of two, >=2.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  byte address
- cmd_data_i  in  DATA_WIDTH  write data
- cmd_strb_i  in  DATA_WIDTH/8  write strobe
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_write_o  out  1  response belongs to a write
- rsp_data_o  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp_o  out  2  AXI BRESP/RRESP
- req_o  out  req_t  AXI request
- resp_i  in  resp_t  AXI response
- busy_o  out  1  command FIFO non-empty or credits>0
- err_cnt_o  out  16  error counter (see Optional Feature)

Behaviour:
- Reset (arst_ni low, asynchronous): all *_valid in req_o=0, b_ready=r_ready=0, rsp_valid_o=0, cmd_ready_o=0, busy_o=0, err_cnt_o=0; FIFOs emptied; credit counter=0; FSM=IDLE. Mid-transaction reset abandons in-flight commands silently. cmd_ready_o goes 1 on the first clk_i edge after release.
- Command FIFO: push on cmd_valid_i&&cmd_ready_o. Simultaneous push and pop when full is allowed.
- AXI field values:
  - id=0, len=0, size=$clog2(DATA_WIDTH/8), burst=INCR(1).
  - lock/cache/prot/qos/region/user/atop=0.
  - addr = cmd_addr with low $clog2(DATA_WIDTH/8) bits cleared.
  - w.last=1.
- Credit counter: +1 per command popped for issue, -1 per response popped at the output (rsp_valid_o&&rsp_ready_i). Simultaneous +1/-1 leaves it unchanged.
- Issue gate: credits<MAX_OUTSTANDING, and (credits==0 or head type == type of last issued command). Type switches therefore wait for full drain, which guarantees in-order responses with a single ID.
- FSM:
  - IDLE: gate true and FIFO non-empty -> pop head, register it, credit+1. Write -> WR (aw_valid=w_valid=1); read -> RD (ar_valid=1).
  - WR: aw_valid and w_valid each drop independently on their own handshake; either order or the same cycle is legal. Both done -> IDLE.
  - RD: ar handshake -> IDLE.
- Valids never drop and payloads never change before handshake.
- Minimum issue latency: command accepted at edge N, valid asserted after edge N+1. Back-to-back same-type issue: 1 command per 2 cycles.
- Response FIFO: depth MAX_OUTSTANDING. b_ready=r_ready=1 whenever out of reset; credits guarantee no overflow.
  - B beat -> push {write=1, data=0, resp}.
  - R beat -> push {write=0, data, resp}.
  - FIFO head drives rsp_*; rsp_valid_o = non-empty. Push into empty FIFO is visible the next cycle.
- rsp_resp_o passes through unchanged; no command retry on SLVERR/DECERR.

Optional Feature:
- Macro AXI_CMD_MASTER_ERR_CNT_EN.
- Defined: err_cnt_o increments by 1 on each B or R handshake with resp!=OKAY(0). Saturates at 16'hFFFF; cleared only by reset.
- Undefined: err_cnt_o tied to 0 and no counter flops exist.

Test Plan:
- Write 0x40000000 data 0xFEDCBA9876543210 strb 0xFF, then read 0x40000000 -> rsp1 write=1 resp=0; rsp2 write=0 data=0xFEDCBA9876543210 resp=0.
- Three queued writes to 0x40000000 (all-ones/strb 0xA3, all-ones/strb 0x5C, zero/strb 0x55), then read -> data 0xFF00FF00FF00FF00 (with the first case's initial data); three write responses precede the read response.
- Slave holds aw_ready low 5 cycles while w_ready=1 -> w handshakes first, aw_valid stays 1 with stable addr, single B returned.
- rsp_ready_i=0, push 8 reads (MAX_OUTSTANDING=4) -> exactly 4 AR handshakes, then cmd FIFO fills and cmd_ready_o=0; raising rsp_ready_i drains all 8 responses in order.
- Write to unmapped address with slave returning DECERR -> rsp_resp_o=3; err_cnt_o=1 with macro defined, 0 without.
- Assert arst_ni low while aw_valid=1 and 2 credits outstanding -> all valids 0 immediately, busy_o=0; after release a new read completes normally.
